// File: rtl/clk_div_rst_gen.sv
// rtl/clk_div_rst_gen.sv - staggered reset sequencer with per-channel programmable clock dividers
module clk_div_rst_gen #(
    parameter int CH_NUM   = 4,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 1,
    parameter int RST_DLY  = 20,
    parameter int STG_DLY  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [CH_NUM*DIV_W-1:0] DIV_CFG,
    input  logic                    CFG_LD,
    output logic [CH_NUM-1:0]       CLK_EN_O,
    output logic [CH_NUM-1:0]       CLK_DIV_O,
    output logic [CH_NUM-1:0]       RSTN_O,
    output logic                    READY
);

    localparam int DLY_MAX = (RST_DLY > STG_DLY) ? RST_DLY : STG_DLY;
    localparam int CNT_W   = $clog2(DLY_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_DLY - 1);
    localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STG_DLY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        STAGGER = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   dly_cnt;
    logic [CH_NUM-1:0]  rstn_nxt;
    logic [DIV_W-1:0]   shadow [CH_NUM];
    logic [DIV_W-1:0]   cnt    [CH_NUM];

    // Next release pattern; its top bit set means this release is the last one.
    assign rstn_nxt = (RSTN_O << 1) | CH_NUM'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            dly_cnt <= '0;
            RSTN_O  <= '0;
            READY   <= 1'b0;
        end else if (!EN) begin
            state   <= IDLE;
            dly_cnt <= '0;
            RSTN_O  <= '0;
            READY   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= HOLD;
                    dly_cnt <= '0;
                end
                HOLD: begin
                    if (dly_cnt == HOLD_LAST) begin
                        dly_cnt <= '0;
                        RSTN_O  <= rstn_nxt;
                        READY   <= rstn_nxt[CH_NUM-1];
                        state   <= rstn_nxt[CH_NUM-1] ? RUN : STAGGER;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                STAGGER: begin
                    if (dly_cnt == STG_LAST) begin
                        dly_cnt <= '0;
                        RSTN_O  <= rstn_nxt;
                        if (rstn_nxt[CH_NUM-1]) begin
                            READY <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                RUN: begin
                    READY <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A load re-phases every channel and takes priority over a coincident tick.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < CH_NUM; i++) begin
                shadow[i]    <= DIV_W'(DIV_INIT);
                cnt[i]       <= '0;
                CLK_EN_O[i]  <= 1'b0;
                CLK_DIV_O[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (CFG_LD) begin
                    shadow[i] <= DIV_CFG[i*DIV_W +: DIV_W];
                end
                if (!EN || state == IDLE || CFG_LD) begin
                    cnt[i]       <= '0;
                    CLK_EN_O[i]  <= 1'b0;
                    CLK_DIV_O[i] <= 1'b0;
                end else if (cnt[i] == shadow[i]) begin
                    cnt[i]       <= '0;
                    CLK_EN_O[i]  <= 1'b1;
                    CLK_DIV_O[i] <= ~CLK_DIV_O[i];
                end else begin
                    cnt[i]       <= cnt[i] + 1'b1;
                    CLK_EN_O[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_rst_gen.sv
// tb/tb_clk_div_rst_gen.sv - directed self-checking bench for clk_div_rst_gen
module tb_clk_div_rst_gen;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic [31:0] DIV_CFG;
    logic        CFG_LD;
    logic [3:0]  CLK_EN_O;
    logic [3:0]  CLK_DIV_O;
    logic [3:0]  RSTN_O;
    logic        READY;

    int pass_cnt;
    int total_cnt;
    int j;
    int d [4];

    clk_div_rst_gen #(
        .CH_NUM  (4),
        .DIV_W   (8),
        .DIV_INIT(1),
        .RST_DLY (20),
        .STG_DLY (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .DIV_CFG  (DIV_CFG),
        .CFG_LD   (CFG_LD),
        .CLK_EN_O (CLK_EN_O),
        .CLK_DIV_O(CLK_DIV_O),
        .RSTN_O   (RSTN_O),
        .READY    (READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // j = number of counting edges since counters last left the cleared state
    function automatic logic [3:0] exp_en();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (j >= 1 && (j % (d[i] + 1)) == 0) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] exp_div();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (j >= 0 && ((j / (d[i] + 1)) % 2) == 1) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] exp_rstn(input int k);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (k >= 21 + 4 * i) r[i] = 1'b1;
        return r;
    endfunction

    task automatic div_step();
        @(posedge CLK);
        #1;
        j++;
        chk("clk_en", CLK_EN_O, exp_en());
        chk("clk_div", CLK_DIV_O, exp_div());
    endtask

    // k counts edges with EN=1 starting from the IDLE->HOLD edge
    task automatic seq_step(input int k);
        @(posedge CLK);
        #1;
        j = k - 1;
        chk("seq_clk_en", CLK_EN_O, exp_en());
        chk("seq_clk_div", CLK_DIV_O, exp_div());
        chk("seq_rstn", RSTN_O, exp_rstn(k));
        chk("seq_ready", READY, (k >= 33) ? 1 : 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rstn"}, RSTN_O, 0);
        chk({tag, "_ready"}, READY, 0);
        chk({tag, "_clk_en"}, CLK_EN_O, 0);
        chk({tag, "_clk_div"}, CLK_DIV_O, 0);
    endtask

    initial begin
        CLK = 1'b0; RST = 1'b0; EN = 1'b0; CFG_LD = 1'b0; DIV_CFG = '0;
        pass_cnt = 0; total_cnt = 0; j = 0;
        for (int i = 0; i < 4; i++) d[i] = 1;

        #2 RST = 1'b1;
        #1 chk_idle("reset");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        EN  = 1'b1;

        // power-up: releases at 21/25/29/33, dividers at DIV_INIT during sequencing
        for (int k = 1; k <= 34; k++) seq_step(k);

        // D0=3, D1=0, D2=255, D3=1
        DIV_CFG = {8'd1, 8'd255, 8'd0, 8'd3};
        CFG_LD  = 1'b1;
        d[0] = 3; d[1] = 0; d[2] = 255; d[3] = 1;
        j = -1;
        div_step();
        CFG_LD = 1'b0;
        repeat (603) div_step();
        chk("ready_after_load", READY, 1);

        // counter0 is 3 here: the reload edge would have ticked channel 0
        DIV_CFG = {8'd1, 8'd255, 8'd0, 8'd1};
        CFG_LD  = 1'b1;
        d[0] = 1;
        j = -1;
        div_step();
        CFG_LD = 1'b0;
        chk("reload_ready", READY, 1);
        chk("reload_rstn", RSTN_O, 4'hf);
        div_step();
        chk("reload_en0_j1", CLK_EN_O[0], 0);
        div_step();
        chk("reload_en0_j2", CLK_EN_O[0], 1);
        repeat (8) div_step();

        // leave RUN via EN, then abort the restarted sequence in STAGGER
        EN = 1'b0;
        @(posedge CLK);
        #1 chk_idle("en_low");
        EN = 1'b1;
        for (int k = 1; k <= 27; k++) seq_step(k);
        EN      = 1'b0;
        CFG_LD  = 1'b1;
        DIV_CFG = '0;
        @(posedge CLK);
        #1 chk_idle("abort");
        CFG_LD = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 0;
        @(posedge CLK);
        #1 chk_idle("idle_hold");
        EN = 1'b1;
        for (int k = 1; k <= 34; k++) seq_step(k);

        // asynchronous reset pulse mid-RUN
        #2 RST = 1'b1;
        #1 chk_idle("async_rst");
        #2 RST = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 1;
        for (int k = 1; k <= 40; k++) seq_step(k);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
